// File: rtl/nios2_oci_dbg_pkg.sv
// nios2_oci_dbg_pkg: shared types and widths for the OCI debug trace capture slice
package nios2_oci_dbg_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_FROZEN} state_e;
    localparam int TOTAL_W = 32;
    function automatic int entry_w(input int count_w, input int data_w);
        return count_w + data_w;
    endfunction
endpackage

// File: rtl/oci_trace_ram.sv
// oci_trace_ram: DEPTH x W register array, synchronous write, asynchronous read
module oci_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/nios2_oci_dct_trace_capture.sv
// nios2_oci_dct_trace_capture: ring-buffer capture of debug-trace words, frozen on
// end-of-test and drained over a show-ahead valid/ready port
module nios2_oci_dct_trace_capture
    import nios2_oci_dbg_pkg::*;
#(
    parameter int DATA_W    = 30,
    parameter int COUNT_W   = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int WRAP_MODE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic [DATA_W-1:0]          dct_buffer,
    input  logic [COUNT_W-1:0]         dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    input  logic                       rd_ready,
    output logic [COUNT_W+DATA_W-1:0]  rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic                       frozen,
    output logic [31:0]                capture_total
);
    localparam int EW = entry_w(COUNT_W, DATA_W);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int PW = POST_TRIG > 1 ? $clog2(POST_TRIG) : 1;

    state_e              state_q, state_d;
    logic [PW-1:0]       post_q, post_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                ovf_q, ovf_d, frozen_q;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic                clear, qual, full, we, pop;
    logic [EW-1:0]       ram_rdata;

    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        case (state_q)
            ST_IDLE:   if (arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (test_has_ended) state_d = ST_FROZEN;
                else if (test_ending) begin
                    state_d = POST_TRIG == 0 ? ST_FROZEN : ST_POST;
                    post_d  = PW'(POST_TRIG - 1);
                end
            end
            ST_POST: begin
                if (test_has_ended || post_q == '0) state_d = ST_FROZEN;
                else post_d = post_q - 1'b1;
            end
            ST_FROZEN: if (arm) state_d = ST_ARMED;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign clear    = arm && (state_q == ST_IDLE || state_q == ST_FROZEN);
    assign qual     = dct_count != '0 && (state_q == ST_ARMED || state_q == ST_POST);
    assign full     = fill_q == FW'(DEPTH);
    assign we       = qual && (!full || WRAP_MODE != 0);
    assign rd_valid = state_q == ST_FROZEN && fill_q != '0;
    assign pop      = rd_valid && rd_ready;

    // an overwrite of the oldest entry drags rd_ptr along so fill stays at DEPTH
    assign wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(we);
    assign rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(pop || (we && full));
    assign fill_d   = clear ? '0 : fill_q + FW'(we && !full) - FW'(pop);
    assign ovf_d    = clear ? 1'b0 : ovf_q || (qual && full);
    assign total_d  = clear ? '0 : (qual && total_q != '1) ? total_q + 1'b1 : total_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            post_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            total_q  <= '0;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            post_q   <= post_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            total_q  <= total_d;
            frozen_q <= state_d == ST_FROZEN;
        end
    end

    oci_trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({dct_count, dct_buffer}),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign rd_data       = rd_valid ? ram_rdata : '0;
    assign fill_level    = fill_q;
    assign overflow      = ovf_q;
    assign frozen        = frozen_q;
    assign capture_total = total_q;
endmodule

// File: doc/nios2_oci_dct_trace_capture.md
Name: nios2_oci_dct_trace_capture

Overview:
Parametrised successor to the OCI debug test-bench monitor. It captures debug-trace words (dct_buffer/dct_count) into an on-chip ring buffer while armed, and freezes on the test_ending/test_has_ended handshake after a programmable post-trigger window. Once frozen, it drains the captured history over a valid/ready read port. It sits beside the Nios II OCI block in simulation and debug builds.

Parameters:
DATA_W, 30, width of dct_buffer
COUNT_W, 4, width of dct_count
DEPTH, 16, buffer entries; power of two, >= 2
POST_TRIG, 4, cycles captured after test_ending before freezing; 0 allowed
WRAP_MODE, 1, 1 = overwrite oldest entry when full; 0 = drop new entry when full

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
arm  in  1  start or restart capture (pulse)
dct_buffer  in  DATA_W  trace payload
dct_count  in  COUNT_W  entries valid in payload; 0 = no capture this cycle
test_ending  in  1  end-of-test trigger; starts post-trigger window
test_has_ended  in  1  immediate freeze
rd_ready  in  1  consumer accepts rd_data
rd_data  out  COUNT_W+DATA_W  {count, buffer} of the oldest entry
rd_valid  out  1  rd_data valid; asserted only in FROZEN
fill_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  out  1  sticky; set when any entry was lost or overwritten
frozen  out  1  high in FROZEN state
capture_total  out  32  count of qualifying capture cycles, saturating

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; wr_ptr and rd_ptr 0.
  - All outputs 0.
  - Reset asserted mid-operation discards the buffer contents and state at the next edge.
- State machine: IDLE, ARMED, POST, FROZEN.
  - IDLE -> ARMED on arm.
  - ARMED -> FROZEN on test_has_ended. test_has_ended takes priority over test_ending in the same cycle.
  - ARMED -> POST on test_ending with POST_TRIG > 0. The post counter loads POST_TRIG-1.
  - ARMED -> FROZEN on test_ending with POST_TRIG = 0.
  - POST: the counter decrements each cycle; at 0 -> FROZEN. test_has_ended -> FROZEN immediately.
  - FROZEN -> ARMED on arm. This clears pointers, fill_level, overflow and capture_total.
  - arm is ignored in ARMED and POST.
- Capture qualifier: dct_count != 0, state ARMED or POST (including the cycle test_ending or test_has_ended is sampled).
  - Each qualifying cycle writes {dct_count, dct_buffer} at wr_ptr, then wr_ptr increments modulo DEPTH.
  - capture_total increments, saturating at 32'hFFFFFFFF. Dropped captures still count.
- Full buffer with WRAP_MODE=1: write proceeds; rd_ptr advances; fill_level stays DEPTH; overflow set.
- Full buffer with WRAP_MODE=0: write suppressed; pointers unchanged; overflow set.
- Read port (show-ahead):
  - rd_valid = FROZEN && fill_level != 0.
  - rd_data is the entry at rd_ptr, combinationally presented from the buffer.
  - Pop on rd_valid && rd_ready: rd_ptr increments modulo DEPTH and fill_level decrements. The next entry is visible in the following cycle.
  - rd_ready is ignored when rd_valid = 0.
  - rd_data = 0 when rd_valid = 0.
- Reads and writes are never concurrent: writes occur only in ARMED/POST, reads only in FROZEN.
- Pointer wrap: ptr width $clog2(DEPTH); wrap from DEPTH-1 to 0 is natural overflow.
- frozen is registered and equals (state == FROZEN).

Decomposition:
- Shared package nios2_oci_dbg_pkg:
  - state enum (IDLE, ARMED, POST, FROZEN).
  - entry-width function COUNT_W+DATA_W.
  - capture_total width constant 32.
- One sub-module, oci_trace_ram: DEPTH x (COUNT_W+DATA_W) register array with synchronous write and asynchronous read. It carries no control logic.

Test Plan:
- DEPTH=8, POST_TRIG=2: reset, arm, 5 captures (count=1..5, buffer=0x100+i), test_has_ended -> frozen=1, fill_level=5; drain with rd_ready=1 yields 5 entries in order, then rd_valid=0; overflow=0, capture_total=5.
- WRAP_MODE=1, DEPTH=8: 11 captures i=0..10, then freeze -> fill_level=8, overflow=1, first drained buffer=0x103, last=0x10A, capture_total=11.
- WRAP_MODE=0, DEPTH=8: 11 captures -> fill_level=8, overflow=1, drained buffers 0x100..0x107, capture_total=11.
- POST_TRIG=2: test_ending with capture active every cycle -> exactly 2 further entries after the trigger cycle, then frozen=1. The same cycle with test_has_ended also high -> frozen next edge with no post entries.
- Drain 3 of 5 entries with rd_ready toggling (1,0,1,0,1) -> pops only on ready-high cycles, fill_level=2. Then arm -> ARMED, fill_level=0, overflow=0, capture_total=0, rd_valid=0.
- Reset asserted for 1 cycle while in POST with fill_level=4 -> all outputs 0 next edge, state IDLE; dct_count!=0 without arm -> no capture.
